// File: rtl/tgdemux_pkg.sv
// -----------------------------------------------------------------------------
// tgdemux_pkg
// Shared types and helpers for the 2:1 word demux capture path.
//   demux_state_t   : pairing FSM state (IDLE = waiting for lane A,
//                     GOT_A = lane-A word captured, waiting for lane B)
//   DEMUX_WIDTH_DEF : default lane word width
//   sat_inc()       : saturating increment, used by the event counters
// -----------------------------------------------------------------------------
package tgdemux_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GOT_A = 1'b1
   } demux_state_t;

   localparam int DEMUX_WIDTH_DEF = 8;
   localparam int DEMUX_CNT_W_MAX = 32;

   // Increment cnt unless it already equals max (the all-ones value of the
   // caller's counter width). Counters up to DEMUX_CNT_W_MAX bits are supported.
   function automatic logic [DEMUX_CNT_W_MAX-1:0] sat_inc(
      input logic [DEMUX_CNT_W_MAX-1:0] cnt,
      input logic [DEMUX_CNT_W_MAX-1:0] max
   );
      return (cnt == max) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/tgdemux2_capture_sel_glitch_filter.sv
// -----------------------------------------------------------------------------
// sel_glitch_filter
// Debounces the lane indicator of the muxed bus. The effective sel (esel) of a
// valid sample follows in_sel only once two consecutive valid samples agree;
// the first disagreeing sample keeps the previous esel. This rides out mux
// settling right after a sel toggle. Only valid samples advance the filter.
// Used by tgdemux2_capture when DEMUX_GLITCH_FILTER_EN is defined.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset (filter state -> 0)
//   in_sel   in  raw lane indicator
//   in_valid in  in_sel qualifies this cycle
//   esel     out filtered lane indicator for the current sample
// -----------------------------------------------------------------------------
module sel_glitch_filter (
   input  logic clk,
   input  logic rst_n,
   input  logic in_sel,
   input  logic in_valid,
   output logic esel
);

   logic filt_q;  // esel applied to the previous valid sample
   logic last_q;  // raw in_sel of the previous valid sample

   // Agreement with the previous raw sample makes the new value stick;
   // otherwise the established value is kept for this sample.
   assign esel = (in_sel == last_q) ? in_sel : filt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         last_q <= 1'b0;
      end else if (in_valid) begin
         filt_q <= esel;
         last_q <= in_sel;
      end
   end

endmodule

// File: rtl/tgdemux2_capture.sv
// -----------------------------------------------------------------------------
// tgdemux2_capture
// Receive end of the 2:1 word mux path. Rebuilds {lane A, lane B} word pairs
// from a time-multiplexed bus and presents each pair through a one-entry
// valid/ready holding register.
// Optional feature: define DEMUX_GLITCH_FILTER_EN to debounce in_sel through
// sel_glitch_filter; otherwise in_sel is used directly with no added latency.
// Parameters:
//   WIDTH  bits per lane word
//   CNT_W  width of the saturating orphan/overflow counters (<= 32)
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_data    in   muxed bus sample
//   in_sel     in   lane of in_data (0 = A, 1 = B)
//   in_valid   in   in_data/in_sel qualify this cycle
//   out_a      out  lane-A word of the held pair
//   out_b      out  lane-B word of the held pair
//   out_valid  out  pair held, stable until accepted
//   out_ready  in   consumer accepts when out_valid & out_ready
//   orphan_cnt out  B samples seen with no pending A (saturating)
//   ovf_cnt    out  pairs dropped because the holding register was full
// -----------------------------------------------------------------------------
module tgdemux2_capture
   import tgdemux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] orphan_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   demux_state_t     state, state_nxt;
   logic             esel;
   logic [WIDTH-1:0] a_reg;
   logic             load_a;
   logic             pair_done;
   logic             orphan_hit;
   logic             hold_free;

   // ---------------------------------------------------------------------------
   // Effective lane indicator
   // ---------------------------------------------------------------------------
`ifdef DEMUX_GLITCH_FILTER_EN
   sel_glitch_filter u_sel_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .esel     (esel)
   );
`else
   assign esel = in_sel;
`endif

   // ---------------------------------------------------------------------------
   // Pairing FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with <= so every always_ff block samples the
   // pre-edge value; a blocking = here would create evaluation-order races.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Pairing FSM: next state (only a valid sample moves it)
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if (in_valid) begin
         unique case (state)
            IDLE:  if (!esel) state_nxt = GOT_A;
            GOT_A: if (esel)  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Pairing FSM: per-sample strobes
   //   load_a     : lane-A word captured (last one wins while sel stays low)
   //   pair_done  : lane-B word completes the pair {a_reg, in_data}
   //   orphan_hit : lane-B word with nothing pending
   // ---------------------------------------------------------------------------
   always_comb begin
      load_a     = 1'b0;
      pair_done  = 1'b0;
      orphan_hit = 1'b0;
      if (in_valid) begin
         if (!esel)               load_a     = 1'b1;
         else if (state == GOT_A) pair_done  = 1'b1;
         else                     orphan_hit = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Lane-A capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n)      a_reg <= '0;
      else if (load_a) a_reg <= in_data;
   end

   // ---------------------------------------------------------------------------
   // Holding register. A slot being accepted this cycle counts as free, so a
   // new pair can follow an accepted one back to back.
   // ---------------------------------------------------------------------------
   assign hold_free = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_a     <= '0;
         out_b     <= '0;
         out_valid <= 1'b0;
      end else if (pair_done && hold_free) begin
         out_a     <= a_reg;
         out_b     <= in_data;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;  // data words keep their last value
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating event counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         orphan_cnt <= '0;
         ovf_cnt    <= '0;
      end else begin
         if (orphan_hit)
            orphan_cnt <= CNT_W'(sat_inc(DEMUX_CNT_W_MAX'(orphan_cnt),
                                         DEMUX_CNT_W_MAX'(CNT_MAX)));
         if (pair_done && !hold_free)
            ovf_cnt <= CNT_W'(sat_inc(DEMUX_CNT_W_MAX'(ovf_cnt),
                                      DEMUX_CNT_W_MAX'(CNT_MAX)));
      end
   end

endmodule

// File: tb/tb_tgdemux2_capture.sv
// -----------------------------------------------------------------------------
// tb_tgdemux2_capture
// Self-checking bench for tgdemux2_capture. A transaction-level reference
// model (pending A word, one-slot output buffer, event counts) is stepped once
// per clock and compared with every DUT output each cycle; directed scenarios
// add explicit expected constants. Honours DEMUX_GLITCH_FILTER_EN.
// -----------------------------------------------------------------------------
module tb_tgdemux2_capture;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_sel;
   logic         in_valid;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   orphan_cnt;
   logic [7:0]   ovf_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit           m_have_a;
   logic [W-1:0] m_a;
   bit           m_hv;
   logic [W-1:0] m_ha, m_hb;
   int           m_orph, m_ovf;
   bit           m_fe, m_last;   // filtered sel / previous raw sel (filter builds)

   tgdemux2_capture #(.WIDTH(W), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .orphan_cnt (orphan_cnt),
      .ovf_cnt    (ovf_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge of the reference model, applied to the inputs present
   // at that edge.
   task automatic model_step(input bit rst, input bit v, input bit s,
                             input logic [W-1:0] d, input bit r);
      bit e;
      bit done;
      logic [W-1:0] pa, pb;
      if (!rst) begin
         m_have_a = 0; m_a = '0; m_hv = 0; m_ha = '0; m_hb = '0;
         m_orph = 0; m_ovf = 0; m_fe = 0; m_last = 0;
         return;
      end
      done = 0;
      pa = '0;
      pb = '0;
`ifdef DEMUX_GLITCH_FILTER_EN
      e = (s == m_last) ? s : m_fe;
      if (v) begin
         m_fe   = e;
         m_last = s;
      end
`else
      e = s;
`endif
      if (v) begin
         if (!e) begin
            m_have_a = 1;
            m_a      = d;
         end else if (m_have_a) begin
            done     = 1;
            pa       = m_a;
            pb       = d;
            m_have_a = 0;
         end else begin
            m_orph = (m_orph < 255) ? m_orph + 1 : 255;
         end
      end
      if (done) begin
         if (!m_hv || r) begin
            m_hv = 1; m_ha = pa; m_hb = pb;
         end else begin
            m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
         end
      end else if (m_hv && r) begin
         m_hv = 0;
      end
   endtask

   // Drive inputs (called at a falling edge), let one rising edge pass,
   // then compare all outputs with the model at the following falling edge.
   task automatic cycle(input bit rst, input bit v, input bit s,
                        input logic [W-1:0] d, input bit r);
      rst_n     = rst;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      model_step(rst, v, s, d, r);
      @(negedge clk);
      check("out_valid",  32'(out_valid),  32'(m_hv));
      check("out_a",      32'(out_a),      32'(m_ha));
      check("out_b",      32'(out_b),      32'(m_hb));
      check("orphan_cnt", 32'(orphan_cnt), 32'(m_orph));
      check("ovf_cnt",    32'(ovf_cnt),    32'(m_ovf));
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++)
         cycle(0, 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
   endtask

   initial begin
      logic [W-1:0] bw;
      rst_n = 0; in_valid = 0; in_sel = 0; in_data = '0; out_ready = 0;
      @(negedge clk);

      // reset with random inputs: everything cleared
      do_reset();
      check("rst_valid",  32'(out_valid),  32'd0);
      check("rst_a",      32'(out_a),      32'd0);
      check("rst_b",      32'(out_b),      32'd0);
      check("rst_orphan", 32'(orphan_cnt), 32'd0);
      check("rst_ovf",    32'(ovf_cnt),    32'd0);

`ifndef DEMUX_GLITCH_FILTER_EN
      // basic pair, consumer always ready: one-cycle out_valid pulse
      cycle(1, 1, 0, 8'hF0, 1);
      check("basic_pre_valid", 32'(out_valid), 32'd0);
      cycle(1, 1, 1, 8'hCC, 1);
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_a",     32'(out_a),     32'hF0);
      check("basic_b",     32'(out_b),     32'hCC);
      cycle(1, 0, 0, 8'h00, 1);
      check("basic_drop",  32'(out_valid), 32'd0);

      // sel pattern {0,0,0,0,0,0,1,1} x4
      do_reset();
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 8; k++) begin
            bw = (k == 6) ? 8'hAA : 8'hBB;
            cycle(1, 1, k >= 6, (k < 6) ? W'(k + 1) : bw, 1);
            if (k == 6) begin
               check("pat_valid", 32'(out_valid), 32'd1);
               check("pat_a",     32'(out_a),     32'h06);
               check("pat_b",     32'(out_b),     32'hAA);
            end
         end
      end
      check("pat_orphans", 32'(orphan_cnt), 32'd4);

      // backpressure: second pair dropped, first held stable
      do_reset();
      cycle(1, 1, 0, 8'h11, 0);
      cycle(1, 1, 1, 8'h22, 0);
      cycle(1, 1, 0, 8'h33, 0);
      cycle(1, 1, 1, 8'h44, 0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_a",     32'(out_a),     32'h11);
      check("bp_b",     32'(out_b),     32'h22);
      check("bp_ovf",   32'(ovf_cnt),   32'd1);
      cycle(1, 0, 0, 8'h00, 1);
      check("bp_accept", 32'(out_valid), 32'd0);
      check("bp_keep_a", 32'(out_a),     32'h11);

      // reset while in GOT_A discards the pending A word
      do_reset();
      cycle(1, 1, 0, 8'h5A, 1);
      cycle(0, 0, 0, 8'h00, 1);
      cycle(1, 1, 1, 8'hC3, 1);
      check("midrst_valid",  32'(out_valid),  32'd0);
      check("midrst_orphan", 32'(orphan_cnt), 32'd1);

      // orphan counter saturates at all-ones
      do_reset();
      for (int i = 0; i < 260; i++) cycle(1, 1, 1, W'($urandom), 1);
      check("orphan_sat", 32'(orphan_cnt), 32'hFF);
`else
      // single-cycle sel glitch inside an A run: no pair; two highs: one pair
      cycle(1, 1, 0, 8'h01, 1);
      cycle(1, 1, 0, 8'h02, 1);
      cycle(1, 1, 1, 8'h77, 1);
      check("glitch_no_pair", 32'(out_valid), 32'd0);
      cycle(1, 1, 0, 8'h03, 1);
      cycle(1, 1, 1, 8'h88, 1);
      check("glitch_first_hi", 32'(out_valid), 32'd0);
      cycle(1, 1, 1, 8'h99, 1);
      check("filt_pair_valid", 32'(out_valid), 32'd1);
      check("filt_pair_a",     32'(out_a),     32'h88);
      check("filt_pair_b",     32'(out_b),     32'h99);
      check("filt_orphans",    32'(orphan_cnt), 32'd0);
`endif

      // randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(99) != 0), ($urandom_range(3) != 0),
               1'($urandom), W'($urandom), ($urandom_range(2) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
